wb_arbiter_rr_n: RTL and testbench

Parameterised N-master to 1-slave Wishbone pipelined arbiter with round-robin fairness and cycle-level bus ownership. It sits in the interconnect in front of shared slaves such as the DDR port and the shared SRAM, where more than two masters contend: CPU instruction port, CPU data port, DMA and debug. Ownership is held for a complete Wishbone cycle (cyc high). An optional watchdog aborts a hung slave so the granted master is released.

---
 rtl/wb_arbiter_rr_n.sv | 151 +++++++++++++++
 tb/tb_wb_arbiter_rr_n.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_rr_n.sv
// rtl/wb_arbiter_rr_n.sv - N-master round-robin Wishbone pipelined arbiter with cycle-level ownership
// Define WB_ARB_TIMEOUT_EN to compile in the hung-slave watchdog.
module wb_arbiter_rr_n #(
   parameter int NUM_MASTERS    = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_MASTERS-1:0]              wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]              wbm_stb_i,
   input  logic [NUM_MASTERS-1:0]              wbm_we_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   wbm_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   wbm_dat_i,
   input  logic [NUM_MASTERS*SELECT_WIDTH-1:0] wbm_sel_i,
   output logic [DATA_WIDTH-1:0]               wbm_dat_o,
   output logic [NUM_MASTERS-1:0]              wbm_ack_o,
   output logic [NUM_MASTERS-1:0]              wbm_err_o,
   output logic [NUM_MASTERS-1:0]              wbm_stall_o,
   output logic                                wbs_cyc_o,
   output logic                                wbs_stb_o,
   output logic                                wbs_we_o,
   output logic [ADDR_WIDTH-1:0]               wbs_adr_o,
   output logic [DATA_WIDTH-1:0]               wbs_dat_o,
   output logic [SELECT_WIDTH-1:0]             wbs_sel_o,
   input  logic [DATA_WIDTH-1:0]               wbs_dat_i,
   input  logic                                wbs_ack_i,
   input  logic                                wbs_err_i,
   input  logic                                wbs_stall_i,
   output logic [NUM_MASTERS-1:0]              grant_o
);
   localparam int IW = $clog2(NUM_MASTERS);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t                 state, state_d;
   logic [IW-1:0]          last_grant, pick_idx, cand;
   logic                   pick_found;
   logic [NUM_MASTERS-1:0] grant_q;
   logic                   owner_cyc;
   logic                   abort, aborted;

   // While OWNED, last_grant is the index of the current owner.
   assign owner_cyc = wbm_cyc_i[last_grant];
   assign grant_o   = grant_q;
   assign wbm_dat_o = wbs_dat_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= IW'(NUM_MASTERS - 1);
         grant_q    <= '0;
      end else begin
         state <= state_d;
         if (state == IDLE && pick_found) begin
            last_grant <= pick_idx;
            grant_q    <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
         end else if (state_d == IDLE) begin
            grant_q <= '0;
         end
      end
   end

   // Walk from farthest to nearest so the master right after last_grant wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         cand = IW'((int'(last_grant) + k) % NUM_MASTERS);
         if (wbm_cyc_i[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
      state_d = state;
      case (state)
         IDLE:    if (pick_found) state_d = OWNED;
         OWNED:   if (!owner_cyc) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wbs_cyc_o   = 1'b0;
      wbs_stb_o   = 1'b0;
      wbs_we_o    = 1'b0;
      wbs_adr_o   = '0;
      wbs_dat_o   = '0;
      wbs_sel_o   = '0;
      wbm_stall_o = '1;
      wbm_ack_o   = '0;
      wbm_err_o   = '0;
      if (state == OWNED) begin
         wbs_cyc_o               = owner_cyc & ~abort;
         wbs_stb_o               = wbm_stb_i[last_grant] & ~abort;
         wbs_we_o                = wbm_we_i[last_grant];
         wbs_adr_o               = wbm_adr_i[int'(last_grant)*ADDR_WIDTH +: ADDR_WIDTH];
         wbs_dat_o               = wbm_dat_i[int'(last_grant)*DATA_WIDTH +: DATA_WIDTH];
         wbs_sel_o               = wbm_sel_i[int'(last_grant)*SELECT_WIDTH +: SELECT_WIDTH];
         wbm_stall_o[last_grant] = wbs_stall_i;
         wbm_ack_o[last_grant]   = wbs_ack_i & ~aborted;
         wbm_err_o[last_grant]   = (wbs_err_i & ~aborted) | abort;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int OW = $clog2(NUM_MASTERS) + 4;

   logic [OW-1:0] outstanding;
   logic [15:0]   wd_cnt;
   logic          accepted, done;

   assign accepted = wbs_cyc_o & wbs_stb_o & ~wbs_stall_i;
   assign done     = (wbs_ack_i | wbs_err_i) & ~aborted;
   assign abort    = (state == OWNED) && (outstanding != '0) && !done &&
                     (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

   // After an abort, responses from the slave are ignored until the cycle ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
         wd_cnt      <= '0;
         aborted     <= 1'b0;
      end else if (state != OWNED || state_d == IDLE) begin
         outstanding <= '0;
         wd_cnt      <= '0;
         aborted     <= 1'b0;
      end else if (abort) begin
         outstanding <= '0;
         wd_cnt      <= '0;
         aborted     <= 1'b1;
      end else begin
         if (accepted && !done && outstanding != '1)
            outstanding <= outstanding + OW'(1);
         else if (!accepted && done && outstanding != '0)
            outstanding <= outstanding - OW'(1);
         if (done)
            wd_cnt <= '0;
         else if (outstanding != '0)
            wd_cnt <= wd_cnt + 16'd1;
      end
   end
`else
   assign abort   = 1'b0;
   assign aborted = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_rr_n.sv
// tb/tb_wb_arbiter_rr_n.sv - scoreboard bench for wb_arbiter_rr_n
module tb_wb_arbiter_rr_n;
   localparam int N  = 4;
   localparam int TO = 8;

   typedef struct packed { logic we; logic [31:0] adr; logic [31:0] dat; } req_t;
   typedef struct packed { logic err; logic [31:0] data; logic [31:0] cyc; } rsp_t;
   typedef struct packed { logic [1:0] m; logic gap; } gnt_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
   logic [N*32-1:0] m_adr = '0, m_dat = '0;
   logic [N*4-1:0]  m_sel = 16'hFFFF;
   logic [31:0]     wbm_dat_o;
   logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_stall_o, grant_o;
   logic            wbs_cyc_o, wbs_stb_o, wbs_we_o;
   logic [31:0]     wbs_adr_o, wbs_dat_o;
   logic [3:0]      wbs_sel_o;
   logic [31:0]     wbs_dat_i = '0;
   logic            wbs_ack_i = 1'b0, wbs_err_i = 1'b0, wbs_stall_i = 1'b0;

   int   cyc_n = 0, rel_cycle = 0, n_vec = 0, n_miss = 0;
   int   slv_stall_cfg = 0, stall_left = 0;
   bit   slv_hang = 1'b0;
   int   resp_cnt [N];
   req_t exp_req [$];
   rsp_t exp_rsp [N][$];
   gnt_t exp_grant [$];

   wb_arbiter_rr_n #(.NUM_MASTERS(N), .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4),
                     .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_we_i(m_we), .wbm_adr_i(m_adr),
      .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o),
      .wbm_err_o(wbm_err_o), .wbm_stall_o(wbm_stall_o),
      .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o), .wbs_adr_o(wbs_adr_o),
      .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i),
      .wbs_err_i(wbs_err_i), .wbs_stall_i(wbs_stall_i), .grant_o(grant_o)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc_n++;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_n);
      end
   endtask

   task automatic exp_gnt(input int m, input bit gap);
      gnt_t g;
      g.m   = 2'(m);
      g.gap = gap;
      exp_grant.push_back(g);
   endtask

   // Slave: acks the cycle after acceptance with data = adr ^ A5A50000, optional stall per request.
   initial begin : slave
      bit          s_acc, s_req;
      logic [31:0] s_adr;
      forever begin
         @(negedge clk);
         s_acc = wbs_cyc_o && wbs_stb_o && !wbs_stall_i;
         s_req = wbs_cyc_o && wbs_stb_o;
         s_adr = wbs_adr_o;
         @(posedge clk); #1;
         wbs_ack_i = s_acc && !slv_hang;
         wbs_dat_i = s_acc ? (s_adr ^ 32'hA5A5_0000) : 32'h0;
         if (s_acc) stall_left = slv_stall_cfg;
         else if (s_req && stall_left > 0) stall_left--;
         wbs_stall_i = (stall_left != 0);
      end
   end

   task automatic run_master(input int m, input int n, input logic [31:0] base, input logic we,
                             input int hold);
      int   issued, acked, elapsed;
      req_t q;
      rsp_t r;
      issued = 0; acked = 0; elapsed = 0;
      m_cyc[m] = 1'b1;
      m_we[m]  = we;
      m_stb[m] = (n > 0);
      m_adr[m*32 +: 32] = base;
      m_dat[m*32 +: 32] = ~base;
      while ((acked < n || elapsed < hold) && elapsed < 300) begin
         @(negedge clk);
         if (m_stb[m] && !wbm_stall_o[m]) begin
            q.we  = we;
            q.adr = m_adr[m*32 +: 32];
            q.dat = m_dat[m*32 +: 32];
            exp_req.push_back(q);
            r.err  = slv_hang;
            r.data = q.adr ^ 32'hA5A5_0000;
            r.cyc  = 32'(cyc_n + TO);
            exp_rsp[m].push_back(r);
            issued++;
         end
         if (wbm_ack_o[m] || wbm_err_o[m]) acked++;
         @(posedge clk); #1;
         elapsed++;
         if (issued < n) begin
            m_adr[m*32 +: 32] = base + 32'(4 * issued);
            m_dat[m*32 +: 32] = ~(base + 32'(4 * issued));
         end else begin
            m_stb[m] = 1'b0;
         end
      end
      check($sformatf("m%0d_responses", m), 32'(acked), 32'(n));
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
      rel_cycle = cyc_n;
      repeat (2) @(negedge clk);
      check($sformatf("m%0d_released", m), grant_o[m], 1'b0);
   endtask

   // Monitor: isolation of non-owners, grant order/timing, slave requests, master responses.
   initial begin : monitor
      logic [N-1:0] prev_g;
      bit           iso_ok;
      gnt_t         g;
      req_t         q;
      rsp_t         r;
      prev_g = '0;
      forever begin
         @(negedge clk); #1;
         iso_ok = 1'b1;
         for (int i = 0; i < N; i++)
            if (!grant_o[i] && (!wbm_stall_o[i] || wbm_ack_o[i] || wbm_err_o[i])) iso_ok = 1'b0;
         check("isolation", iso_ok, 1'b1);
         check("grant_onehot0", $onehot0(grant_o), 1'b1);
         if (grant_o == '0) check("idle_slave", {wbs_cyc_o, wbs_stb_o}, 2'b00);
         if (grant_o != prev_g && grant_o != '0) begin
            if (exp_grant.size() == 0) check("grant_unexpected", grant_o, 4'h0);
            else begin
               g = exp_grant.pop_front();
               check("grant_owner", grant_o, 4'(1) << g.m);
               if (g.gap) check("grant_gap", 32'(cyc_n - rel_cycle), 32'd2);
            end
         end
         prev_g = grant_o;
         if (wbs_cyc_o && wbs_stb_o && !wbs_stall_i) begin
            if (exp_req.size() == 0) check("req_unexpected", wbs_stb_o, 1'b0);
            else begin
               q = exp_req.pop_front();
               check("slave_req", {wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o},
                     {q.we, 4'hF, q.adr, q.dat});
            end
         end
         for (int i = 0; i < N; i++) begin
            if (wbm_ack_o[i] || wbm_err_o[i]) begin
               resp_cnt[i]++;
               if (exp_rsp[i].size() == 0) check("rsp_unexpected", {wbm_err_o[i], wbm_ack_o[i]}, 2'b00);
               else begin
                  r = exp_rsp[i].pop_front();
                  check("rsp_kind", {wbm_err_o[i], wbm_ack_o[i]}, r.err ? 2'b10 : 2'b01);
                  if (!r.err) check("rsp_data", wbm_dat_o, r.data);
                  else begin
                     check("err_cycle", 32'(cyc_n), r.cyc);
                     check("err_slave_cyc", wbs_cyc_o, 1'b0);
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N; i++) resp_cnt[i] = 0;
      repeat (2) @(posedge clk); #1;
      check("rst_grant", grant_o, 4'h0);
      check("rst_stall", wbm_stall_o, 4'hF);
      check("rst_slave", {wbs_cyc_o, wbs_stb_o}, 2'b00);
      check("rst_resp", {wbm_ack_o, wbm_err_o}, 8'h00);
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      check("idle_grant", grant_o, 4'h0);
      check("idle_stall", wbm_stall_o, 4'hF);
      check("idle_cyc", wbs_cyc_o, 1'b0);

      // Three simultaneous requesters: rotation 0,1,2 with one dead cycle between owners.
      exp_gnt(0, 1'b0); exp_gnt(1, 1'b1); exp_gnt(2, 1'b1);
      fork
         run_master(0, 1, 32'h0000_0010, 1'b0, 0);
         run_master(1, 1, 32'h0000_0020, 1'b0, 0);
         run_master(2, 1, 32'h0000_0030, 1'b0, 0);
      join
      @(posedge clk); #1;

      // Master 3 holds the bus 10 cycles while master 1 waits.
      exp_gnt(3, 1'b0); exp_gnt(1, 1'b1);
      fork
         run_master(3, 1, 32'h0000_0040, 1'b0, 10);
         run_master(1, 1, 32'h0000_0050, 1'b0, 0);
      join
      @(posedge clk); #1;

      // Four pipelined writes with a 2-cycle stall on each.
      slv_stall_cfg = 2; stall_left = 2; wbs_stall_i = 1'b1;
      exp_gnt(2, 1'b0);
      run_master(2, 4, 32'h0000_0100, 1'b1, 0);
      slv_stall_cfg = 0; stall_left = 0; wbs_stall_i = 1'b0;
      @(posedge clk); #1;
      check("acks_m0", 32'(resp_cnt[0]), 32'd1);
      check("acks_m1", 32'(resp_cnt[1]), 32'd2);
      check("acks_m2", 32'(resp_cnt[2]), 32'd5);
      check("acks_m3", 32'(resp_cnt[3]), 32'd1);

`ifdef WB_ARB_TIMEOUT_EN
      // Hung slave: watchdog errs the owner TO cycles after acceptance.
      slv_hang = 1'b1;
      exp_gnt(3, 1'b0);
      run_master(3, 1, 32'h0000_0200, 1'b0, 0);
      slv_hang = 1'b0;
      @(posedge clk); #1;
`endif

      // Reset while master 2 owns the bus with a stalled request.
      slv_stall_cfg = 15; stall_left = 15; wbs_stall_i = 1'b1;
      exp_gnt(2, 1'b0);
      m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_adr[64 +: 32] = 32'h0000_0300;
      repeat (3) @(posedge clk); #3;
      check("pre_reset_cyc", wbs_cyc_o, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_rst_cyc", {wbs_cyc_o, wbs_stb_o}, 2'b00);
      check("async_rst_grant", grant_o, 4'h0);
      check("async_rst_stall", wbm_stall_o, 4'hF);
      @(posedge clk); #1;
      m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
      slv_stall_cfg = 0; stall_left = 0; wbs_stall_i = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_gnt(0, 1'b0); exp_gnt(3, 1'b1);
      fork
         run_master(0, 1, 32'h0000_0400, 1'b0, 0);
         run_master(3, 1, 32'h0000_0410, 1'b0, 0);
      join
      @(posedge clk); #1;

      check("grants_left", 32'(exp_grant.size()), 32'd0);
      check("reqs_left", 32'(exp_req.size()), 32'd0);
      for (int i = 0; i < N; i++)
         check($sformatf("rsp_left_m%0d", i), 32'(exp_rsp[i].size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
